// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-back arbiter and scoreboard, one per warp.
// Round-robin over ALU/LSU/V2S with r0/r31 protection and RAW/WAW tracking.
package wb_pkg;
    typedef enum logic [1:0] {
        ALU_OUT          = 2'd0,
        LSU_OUT          = 2'd1,
        VECTOR_TO_SCALAR = 2'd2
    } reg_input_mux_t;
endpackage

module scalar_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SAT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_rd_write,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    output logic                  issue_stall,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  v2s_valid,
    input  logic [4:0]            v2s_rd,
    input  logic [DATA_WIDTH-1:0] v2s_data,
    output logic                  v2s_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output reg_input_mux_t        rf_src,
    output logic [31:0]           pending_mask,
    output logic [SAT_WIDTH-1:0]  blocked_count
);

    logic [2:0]            req;
    logic [2:0]            gnt;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [4:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    reg_input_mux_t        sel_src;
    logic                  xfer;
    logic                  drop31;
    logic                  do_write;
    logic                  issue_set;

    logic                  rf_we_q, rf_we_d;
    logic [4:0]            rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    reg_input_mux_t        rf_src_q, rf_src_d;
    logic                  clr_v_q, clr_v_d;
    logic [4:0]            clr_addr_q, clr_addr_d;
    logic [31:0]           pending_q, pending_d;
    logic [SAT_WIDTH-1:0]  blocked_q, blocked_d;

    assign req = {v2s_valid, lsu_valid, alu_valid};

    // Grants are forced low while reset is held, independent of the flops.
    always_comb begin
        gnt = 3'b000;
        unique case (rr_ptr_q)
            2'd1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
        if (!reset) gnt = 3'b000;
    end

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign v2s_ready = gnt[2];

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_src  = ALU_OUT;
        unique case (1'b1)
            gnt[0]: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
                sel_src  = ALU_OUT;
            end
            gnt[1]: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
                sel_src  = LSU_OUT;
            end
            gnt[2]: begin
                sel_rd   = v2s_rd;
                sel_data = v2s_data;
                sel_src  = VECTOR_TO_SCALAR;
            end
            default: ;
        endcase
    end

    assign xfer     = |gnt;
    assign drop31   = xfer && (sel_rd == 5'd31) && !gnt[2];
    assign do_write = xfer && (sel_rd != 5'd0) && !drop31;

    assign issue_stall = issue_valid &&
        ((pending_q[issue_rs1] && (issue_rs1 != 5'd0)) ||
         (pending_q[issue_rs2] && (issue_rs2 != 5'd0)) ||
         (issue_rd_write && pending_q[issue_rd] && (issue_rd != 5'd0)));

    assign issue_set = issue_valid && issue_rd_write &&
                       !issue_stall && (issue_rd != 5'd0);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        unique case (1'b1)
            gnt[0]:  rr_ptr_d = 2'd1;
            gnt[1]:  rr_ptr_d = 2'd2;
            gnt[2]:  rr_ptr_d = 2'd0;
            default: ;
        endcase

        rf_we_d    = do_write;
        rf_waddr_d = do_write ? sel_rd   : rf_waddr_q;
        rf_wdata_d = do_write ? sel_data : rf_wdata_q;
        rf_src_d   = do_write ? sel_src  : rf_src_q;

        // Dropped writes still retire their scoreboard entry one cycle later.
        clr_v_d    = xfer;
        clr_addr_d = sel_rd;

        blocked_d = blocked_q;
        if (drop31 && (blocked_q != {SAT_WIDTH{1'b1}}))
            blocked_d = blocked_q + 1'b1;

        // Set after clear: the issuing instruction is younger.
        pending_d = pending_q;
        if (clr_v_q)   pending_d[clr_addr_q] = 1'b0;
        if (issue_set) pending_d[issue_rd]   = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= ALU_OUT;
            clr_v_q    <= 1'b0;
            clr_addr_q <= '0;
            pending_q  <= '0;
            blocked_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
            clr_v_q    <= clr_v_d;
            clr_addr_q <= clr_addr_d;
            pending_q  <= pending_d;
            blocked_q  <= blocked_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign rf_src        = rf_src_q;
    assign pending_mask  = pending_q;
    assign blocked_count = blocked_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: vector table, directed corner sequences,
// and a randomized run against a rule-level reference model.
module tb_scalar_wb_arbiter;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_rd_write;
    logic [4:0]    issue_rd, issue_rs1, issue_rs2;
    logic          issue_stall;
    logic          alu_valid, lsu_valid, v2s_valid;
    logic [4:0]    alu_rd, lsu_rd, v2s_rd;
    logic [DW-1:0] alu_data, lsu_data, v2s_data;
    logic          alu_ready, lsu_ready, v2s_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    reg_input_mux_t rf_src;
    logic [31:0]   pending_mask;
    logic [SW-1:0] blocked_count;

    scalar_wb_arbiter #(.DATA_WIDTH(DW), .SAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd_write(issue_rd_write),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .v2s_valid(v2s_valid), .v2s_rd(v2s_rd), .v2s_data(v2s_data),
        .v2s_ready(v2s_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_src(rf_src), .pending_mask(pending_mask),
        .blocked_count(blocked_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        issue_valid = 0; issue_rd_write = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; lsu_valid = 0; v2s_valid = 0;
        alu_rd = 0; lsu_rd = 0; v2s_rd = 0;
        alu_data = 0; lsu_data = 0; v2s_data = 0;
    endtask

    function automatic logic [4:0] rreg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [2:0] rdy3();
        return {v2s_ready, lsu_ready, alu_ready};
    endfunction

    typedef struct {
        logic [2:0] v;
        logic [2:0] rdy;
        logic       we;
        logic [4:0] waddr;
    } vec_t;

    vec_t tbl[13];

    int            m_rr;
    logic [31:0]   m_pend;
    int            m_blk;
    logic          m_we;
    logic [4:0]    m_waddr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_src;
    logic [4:0]    inflight[$];

    initial begin
        logic [2:0]    vv;
        logic [2:0]    rdy_e;
        logic          stall_e;
        logic [4:0]    rd_g;
        logic [DW-1:0] d_g;
        logic          wr;
        logic [4:0]    cq;
        int            g;
        int            p;

        tbl[0]  = '{3'b111, 3'b001, 1'b0, 5'd0};
        tbl[1]  = '{3'b111, 3'b010, 1'b1, 5'd1};
        tbl[2]  = '{3'b111, 3'b100, 1'b1, 5'd2};
        tbl[3]  = '{3'b111, 3'b001, 1'b1, 5'd3};
        tbl[4]  = '{3'b111, 3'b010, 1'b1, 5'd1};
        tbl[5]  = '{3'b111, 3'b100, 1'b1, 5'd2};
        tbl[6]  = '{3'b000, 3'b000, 1'b1, 5'd3};
        tbl[7]  = '{3'b110, 3'b010, 1'b0, 5'd3};
        tbl[8]  = '{3'b001, 3'b001, 1'b1, 5'd2};
        tbl[9]  = '{3'b101, 3'b100, 1'b1, 5'd1};
        tbl[10] = '{3'b100, 3'b100, 1'b1, 5'd3};
        tbl[11] = '{3'b000, 3'b000, 1'b1, 5'd3};
        tbl[12] = '{3'b000, 3'b000, 1'b0, 5'd3};

        // Reset state, with a requester present
        reset = 0;
        clr_in();
        alu_valid = 1;
        #2;
        check("rst_ready", 64'(rdy3()), 64'(3'b000));
        check("rst_we", 64'(rf_we), 64'(1'b0));
        check("rst_waddr", 64'(rf_waddr), 64'(5'd0));
        check("rst_wdata", 64'(rf_wdata), 64'(32'd0));
        check("rst_src", 64'(rf_src), 64'(ALU_OUT));
        check("rst_pend", 64'(pending_mask), 64'(32'd0));
        check("rst_blk", 64'(blocked_count), 64'(8'd0));
        tick();
        reset = 1;
        clr_in();

        // Table: round-robin sequence, producers fixed at rd 1/2/3
        alu_rd = 1; lsu_rd = 2; v2s_rd = 3;
        alu_data = 32'h11; lsu_data = 32'h22; v2s_data = 32'h33;
        for (int i = 0; i < 13; i++) begin
            {v2s_valid, lsu_valid, alu_valid} = tbl[i].v;
            #3;
            check($sformatf("tbl%0d_rdy", i), 64'(rdy3()), 64'(tbl[i].rdy));
            check($sformatf("tbl%0d_we", i), 64'(rf_we), 64'(tbl[i].we));
            check($sformatf("tbl%0d_wa", i), 64'(rf_waddr),
                  64'(tbl[i].waddr));
            tick();
        end
        clr_in();

        // ALU alone, rd=5
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #3;
        check("alu5_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        alu_valid = 0;
        #3;
        check("alu5_we", 64'(rf_we), 64'(1'b1));
        check("alu5_wa", 64'(rf_waddr), 64'(5'd5));
        check("alu5_wd", 64'(rf_wdata), 64'(32'hDEADBEEF));
        check("alu5_src", 64'(rf_src), 64'(ALU_OUT));
        tick();
        #3;
        check("alu5_we_off", 64'(rf_we), 64'(1'b0));
        tick();

        // Hazard on r7
        issue_valid = 1; issue_rd_write = 1; issue_rd = 7;
        #3;
        check("haz_c0_stall", 64'(issue_stall), 64'(1'b0));
        tick();
        issue_rd_write = 0; issue_rd = 0; issue_rs1 = 7;
        #3;
        check("haz_c1_stall", 64'(issue_stall), 64'(1'b1));
        check("haz_c1_pend", 64'(pending_mask), 64'(32'h80));
        tick();
        issue_rs1 = 0; issue_rd_write = 1; issue_rd = 7;
        #3;
        check("haz_waw_stall", 64'(issue_stall), 64'(1'b1));
        tick();
        issue_rd_write = 0; issue_rd = 0; issue_rs1 = 7;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        #3;
        check("haz_c3_stall", 64'(issue_stall), 64'(1'b1));
        check("haz_c3_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        alu_valid = 0;
        #3;
        check("haz_c4_we", 64'(rf_we), 64'(1'b1));
        check("haz_c4_wa", 64'(rf_waddr), 64'(5'd7));
        check("haz_c4_stall", 64'(issue_stall), 64'(1'b1));
        tick();
        #3;
        check("haz_c5_stall", 64'(issue_stall), 64'(1'b0));
        check("haz_c5_pend", 64'(pending_mask), 64'(32'h0));
        tick();
        clr_in();

        // Protection: r31 from ALU blocked, from V2S written, r0 dropped
        alu_valid = 1; alu_rd = 31; alu_data = 32'hFFFF0000;
        #3;
        check("p31_alu_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        alu_valid = 0;
        v2s_valid = 1; v2s_rd = 31; v2s_data = 32'h0000000F;
        #3;
        check("p31_alu_we", 64'(rf_we), 64'(1'b0));
        check("p31_blk1", 64'(blocked_count), 64'(8'd1));
        check("p31_v2s_rdy", 64'(rdy3()), 64'(3'b100));
        tick();
        v2s_valid = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h123;
        #3;
        check("p31_v2s_we", 64'(rf_we), 64'(1'b1));
        check("p31_v2s_wa", 64'(rf_waddr), 64'(5'd31));
        check("p31_v2s_wd", 64'(rf_wdata), 64'(32'hF));
        check("p31_v2s_src", 64'(rf_src), 64'(VECTOR_TO_SCALAR));
        check("p0_lsu_rdy", 64'(rdy3()), 64'(3'b010));
        tick();
        lsu_valid = 0;
        #3;
        check("p0_we", 64'(rf_we), 64'(1'b0));
        check("p0_blk", 64'(blocked_count), 64'(8'd1));
        tick();

        // Same-edge set and clear of r9
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
        #3;
        check("se_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_rd_write = 1; issue_rd = 9;
        #3;
        check("se_stall", 64'(issue_stall), 64'(1'b0));
        check("se_we", 64'(rf_we), 64'(1'b1));
        tick();
        clr_in();
        #3;
        check("se_pend9", 64'(pending_mask), 64'(32'h200));
        tick();

        // Saturate the blocked counter
        alu_valid = 1; alu_rd = 31; alu_data = 32'h5A;
        for (int i = 0; i < 254; i++) tick();
        alu_valid = 0;
        #3;
        check("sat_255", 64'(blocked_count), 64'(8'hFF));
        alu_valid = 1;
        tick();
        alu_valid = 0;
        #3;
        check("sat_hold", 64'(blocked_count), 64'(8'hFF));
        check("sat_we", 64'(rf_we), 64'(1'b0));
        tick();

        // Asynchronous reset with a grant in flight
        alu_valid = 1; alu_rd = 12; alu_data = 32'hAAAA;
        #3;
        check("ar_pre_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        alu_rd = 13; alu_data = 32'hBBBB;
        lsu_valid = 1; lsu_rd = 14; lsu_data = 32'hCCCC;
        v2s_valid = 1; v2s_rd = 15; v2s_data = 32'hDDDD;
        #3;
        check("ar_t_we", 64'(rf_we), 64'(1'b1));
        check("ar_t_wa", 64'(rf_waddr), 64'(5'd12));
        check("ar_t_rdy", 64'(rdy3()), 64'(3'b010));
        #1;
        reset = 0;
        #1;
        check("ar_now_we", 64'(rf_we), 64'(1'b0));
        check("ar_now_wa", 64'(rf_waddr), 64'(5'd0));
        check("ar_now_wd", 64'(rf_wdata), 64'(32'd0));
        check("ar_now_src", 64'(rf_src), 64'(ALU_OUT));
        check("ar_now_pend", 64'(pending_mask), 64'(32'd0));
        check("ar_now_blk", 64'(blocked_count), 64'(8'd0));
        check("ar_now_rdy", 64'(rdy3()), 64'(3'b000));
        tick();
        #3;
        check("ar_in_we", 64'(rf_we), 64'(1'b0));
        reset = 1;
        #1;
        check("ar_rel_rdy", 64'(rdy3()), 64'(3'b001));
        tick();
        #3;
        check("ar_rel_we", 64'(rf_we), 64'(1'b1));
        check("ar_rel_wa", 64'(rf_waddr), 64'(5'd13));
        clr_in();
        tick();

        // Randomized run against the reference model
        reset = 0;
        #2;
        reset = 1;
        m_rr = 0; m_pend = 0; m_blk = 0; m_we = 0;
        m_waddr = 0; m_wdata = 0; m_src = 2'd0;
        inflight.delete();
        for (int n = 0; n < 3000; n++) begin
            vv = 3'($urandom_range(0, 7));
            {v2s_valid, lsu_valid, alu_valid} = vv;
            alu_rd = rreg(); lsu_rd = rreg(); v2s_rd = rreg();
            alu_data = $urandom; lsu_data = $urandom; v2s_data = $urandom;
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_rd_write = ($urandom_range(0, 3) != 0);
            issue_rd = rreg(); issue_rs1 = rreg(); issue_rs2 = rreg();
            #3;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                p = (m_rr + k) % 3;
                if (g < 0 && vv[p]) g = p;
            end
            rdy_e = (g < 0) ? 3'b000 : 3'(1 << g);
            stall_e = issue_valid &&
                ((m_pend[issue_rs1] && issue_rs1 != 0) ||
                 (m_pend[issue_rs2] && issue_rs2 != 0) ||
                 (issue_rd_write && m_pend[issue_rd] && issue_rd != 0));
            check("rnd_rdy", 64'(rdy3()), 64'(rdy_e));
            check("rnd_stall", 64'(issue_stall), 64'(stall_e));
            check("rnd_we", 64'(rf_we), 64'(m_we));
            check("rnd_wa", 64'(rf_waddr), 64'(m_waddr));
            check("rnd_wd", 64'(rf_wdata), 64'(m_wdata));
            check("rnd_src", 64'(rf_src), 64'(m_src));
            check("rnd_pend", 64'(pending_mask), 64'(m_pend));
            check("rnd_blk", 64'(blocked_count), 64'(m_blk));

            if (inflight.size() > 0) begin
                cq = inflight.pop_front();
                m_pend[cq] = 1'b0;
            end
            if (issue_valid && issue_rd_write && !stall_e && issue_rd != 0)
                m_pend[issue_rd] = 1'b1;
            m_we = 1'b0;
            if (g >= 0) begin
                rd_g = (g == 0) ? alu_rd : (g == 1) ? lsu_rd : v2s_rd;
                d_g = (g == 0) ? alu_data : (g == 1) ? lsu_data : v2s_data;
                wr = (rd_g != 0) && !(rd_g == 31 && g != 2);
                inflight.push_back(rd_g);
                if (wr) begin
                    m_we = 1'b1;
                    m_waddr = rd_g;
                    m_wdata = d_g;
                    m_src = 2'(g);
                end
                if (rd_g == 31 && g != 2 && m_blk < 255) m_blk++;
                m_rr = (g + 1) % 3;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
# scalar_wb_arbiter

Write-back arbiter and scoreboard for a warp's scalar register file. It shares the single scalar write port between three producers: ALU, LSU and vector-to-scalar reduction. It enforces the protected-register rules and tracks outstanding destination writes, so the issue stage can stall on RAW/WAW hazards. It sits between the execute units and the scalar register file, one instance per warp.

## Interface
- DATA_WIDTH, 32, width of write data.
- SAT_WIDTH, 8, width of the saturating blocked-write counter.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decoder is issuing an instruction this cycle.
- issue_rd_write  in  1  issued instruction writes a scalar register.
- issue_rd, issue_rs1, issue_rs2  in  5 each  destination/source indices.
- issue_stall  out  1  combinational hazard stall to the issue stage.
- alu_valid / lsu_valid / v2s_valid  in  1 each  producer has a write-back pending.
- alu_rd / lsu_rd / v2s_rd  in  5 each  destination index per producer.
- alu_data / lsu_data / v2s_data  in  DATA_WIDTH each  write data per producer.
- alu_ready / lsu_ready / v2s_ready  out  1 each  combinational grant; transfer when valid&&ready.
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  DATA_WIDTH  registered write data.
- rf_src  out  reg_input_mux_t  source tag: ALU_OUT, LSU_OUT or VECTOR_TO_SCALAR.
- pending_mask  out  32  scoreboard, bit i = write to ri outstanding.
- blocked_count  out  SAT_WIDTH  saturating count of writes dropped by protection.

## Operation
- Arbitration: round-robin over ALU(0), LSU(1), V2S(2). At most one ready per cycle, to the first valid requester starting at rr_ptr. After a grant to i, rr_ptr = (i+1) mod 3. There is no grant when no requester is valid, and rr_ptr is then unchanged.
- Ready depends only on the valid inputs and rr_ptr, never on data or rd.
- Protection on a granted transfer: rd==0 is consumed with no write. rd==31 from ALU or LSU is consumed with no write, and blocked_count increments, saturating at all-ones. rd==31 from V2S writes normally. All other rd values write normally.
- Scoreboard set: at the edge ending the cycle with issue_valid && issue_rd_write && !issue_stall && issue_rd!=0, pending_mask[issue_rd] is set.
- Scoreboard clear: pending_mask[rd] is cleared at the edge where the registered write reaches the register file, i.e. the edge ending the cycle in which rf_we would be high. This includes dropped writes, which clear on the same schedule with rf_we held 0.
- Set and clear of the same bit on one edge: the set wins, because the issuing instruction is younger.
- Stall: issue_stall = issue_valid && (pending[rs1]&&rs1!=0 || pending[rs2]&&rs2!=0 || issue_rd_write&&pending[issue_rd]&&issue_rd!=0). Bit 0 is never set.

## Timing
- Grant in cycle t: rf_we, rf_waddr, rf_wdata and rf_src are valid in cycle t+1 for one cycle. The register file captures at the end of t+1. pending clears at that same edge. issue_stall for that register drops in cycle t+2.
- Throughput is one write per cycle. With no grant, rf_we=0 and the address, data and source outputs hold their previous values.
- Reset (asynchronous, active low, any time): rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=ALU_OUT, pending_mask=0, blocked_count=0, rr_ptr=0. In-flight granted writes are discarded, and producers re-present after reset. All readies are 0 while reset is asserted.

## Test plan
- ALU alone, rd=5, data 0xDEADBEEF: alu_ready high in t. In t+1: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_src=ALU_OUT. rf_we=0 in t+2.
- All three valid for 6 cycles, rd=1/2/3: grant order ALU, LSU, V2S, ALU, LSU, V2S, exactly one ready per cycle.
- Issue rd=7, then three cycles later commit rd=7, with a following issue reading rs1=7 from the cycle after the first issue: issue_stall=1 until pending[7] clears, then 0 the cycle after rf_we. An issue with rd=7 while pending also stalls.
- ALU write to r31, data 0xFFFF0000: consumed, rf_we stays 0, blocked_count=1. Then V2S r31, data 0x0000000F: rf_we=1, rf_src=VECTOR_TO_SCALAR. A write to r0 produces no rf_we and no count change.
- Same edge: issue rd=9 and commit of an older rd=9 write: pending[9] remains 1. blocked_count driven to all-ones stays there on a further blocked write.
- Reset asserted mid-stream while a grant is in flight: all outputs go to reset values immediately, without waiting for a clock. The granted write never appears, and after release the first grant goes to ALU.
